// File: rtl/flash_cfg_arbiter_if.sv
// Requester-side and flash-side config bus bundle for flash_cfg_arbiter.
// The arbiter connects through the slave modport; requesters and the flash
// model (or the surrounding wrapper) use the master modport.
interface flash_cfg_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // requester side
  logic [2*NUM_REQ-1:0]  req_devsel;
  logic [14*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_wren;
  logic [NUM_REQ-1:0]    req_rden;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_expand_enable;
  logic [NUM_REQ-1:0]    req_expand_dir;
  logic [NUM_REQ-1:0]    req_done;
  logic [31:0]           req_rdata;
  logic [1:0]            req_bresp;
  logic [1:0]            req_rresp;

  // flash side
  logic [1:0]            cfg_flsh_devsel;
  logic [13:0]           cfg_flsh_addr;
  logic                  cfg_flsh_wren;
  logic [31:0]           cfg_flsh_wdata;
  logic                  cfg_flsh_rden;
  logic                  cfg_flsh_expand_enable;
  logic                  cfg_flsh_expand_dir;
  logic                  flsh_cfg_done;
  logic [31:0]           flsh_cfg_rdata;
  logic [1:0]            flsh_cfg_bresp;
  logic [1:0]            flsh_cfg_rresp;

  modport slave (
    input  req_devsel, req_addr, req_wren, req_rden, req_wdata,
           req_expand_enable, req_expand_dir,
           flsh_cfg_done, flsh_cfg_rdata, flsh_cfg_bresp, flsh_cfg_rresp,
    output req_done, req_rdata, req_bresp, req_rresp,
           cfg_flsh_devsel, cfg_flsh_addr, cfg_flsh_wren, cfg_flsh_wdata,
           cfg_flsh_rden, cfg_flsh_expand_enable, cfg_flsh_expand_dir
  );

  modport master (
    output req_devsel, req_addr, req_wren, req_rden, req_wdata,
           req_expand_enable, req_expand_dir,
           flsh_cfg_done, flsh_cfg_rdata, flsh_cfg_bresp, flsh_cfg_rresp,
    input  req_done, req_rdata, req_bresp, req_rresp,
           cfg_flsh_devsel, cfg_flsh_addr, cfg_flsh_wren, cfg_flsh_wdata,
           cfg_flsh_rden, cfg_flsh_expand_enable, cfg_flsh_expand_dir
  );
endinterface

// File: rtl/flash_cfg_arbiter.sv
// Round-robin arbiter sharing the single flash config port between NUM_REQ
// requesters, one operation in flight, with a watchdog that aborts an
// operation whose done never comes back.
//
// state | meaning
// IDLE  | waiting; grants the first active requester from the RR pointer
// BUSY  | flash op driven from latched fields, watchdog timer running
// DONE  | one-cycle req_done pulse with captured (or timeout) response
// ERR   | one-cycle req_done pulse for a request with both wren and rden
module flash_cfg_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clock_tlx,
  input  logic              reset,
  flash_cfg_arbiter_if.slave bus,
  input  logic              clr_err,
  output logic              arb_busy,
  output logic [1:0]        arb_grant_id,
  output logic              err_timeout,
  output logic              err_illegal
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE, ST_ERR} state_t;

  state_t              state_q;
  logic [1:0]          ptr_q;
  logic [1:0]          gnt_q;
  logic [TW-1:0]       timer_q;
  logic [1:0]          devsel_q;
  logic [13:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                cfg_wren_q;
  logic                cfg_rden_q;
  logic                exp_en_q;
  logic                exp_dir_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [31:0]         rdata_q;
  logic [1:0]          bresp_q;
  logic [1:0]          rresp_q;
  logic                err_timeout_q;
  logic                err_illegal_q;

  logic [3:0]          act4;
  logic [2:0]          cand;
  logic                pick_vld;
  logic [1:0]          pick_idx;
  logic [1:0]          ptr_d;
  logic [1:0]          pick_devsel;
  logic [13:0]         pick_addr;
  logic [31:0]         pick_wdata;
  logic                pick_wren;
  logic                pick_rden;
  logic                pick_ee;
  logic                pick_ed;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic                timeout_hit;
  logic                illegal_set;

  // Round-robin scan: first active requester at or after the pointer, wrapping.
  always_comb begin
    act4     = 4'b0000;
    cand     = 3'd0;
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      act4[k] = bus.req_wren[k] | bus.req_rden[k];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!pick_vld && act4[cand[1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[1:0];
      end
    end
    ptr_d = (pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick_idx + 2'd1;
  end

  // Field mux for the picked requester plus one-hot forms of pick and grant.
  always_comb begin
    pick_devsel = 2'd0;
    pick_addr   = 14'd0;
    pick_wdata  = 32'd0;
    pick_wren   = 1'b0;
    pick_rden   = 1'b0;
    pick_ee     = 1'b0;
    pick_ed     = 1'b0;
    pick_onehot = '0;
    gnt_onehot  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_onehot[k]  = (gnt_q == 2'(k));
      pick_onehot[k] = (pick_idx == 2'(k));
      if (pick_idx == 2'(k)) begin
        pick_devsel = bus.req_devsel[2*k +: 2];
        pick_addr   = bus.req_addr[14*k +: 14];
        pick_wdata  = bus.req_wdata[32*k +: 32];
        pick_wren   = bus.req_wren[k];
        pick_rden   = bus.req_rden[k];
        pick_ee     = bus.req_expand_enable[k];
        pick_ed     = bus.req_expand_dir[k];
      end
    end
  end

  // Sticky-flag set conditions; a real done on the last timer cycle wins.
  always_comb begin
    timeout_hit = (state_q == ST_BUSY) && !bus.flsh_cfg_done && (timer_q == TMO_LAST);
    illegal_set = (state_q == ST_ERR);
  end

  // Arbitration FSM with registered bus outputs and sticky error flags.
  always_ff @(posedge clock_tlx) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 2'd0;
      gnt_q         <= 2'd0;
      timer_q       <= '0;
      devsel_q      <= 2'd0;
      addr_q        <= 14'd0;
      wdata_q       <= 32'd0;
      cfg_wren_q    <= 1'b0;
      cfg_rden_q    <= 1'b0;
      exp_en_q      <= 1'b0;
      exp_dir_q     <= 1'b0;
      done_q        <= '0;
      rdata_q       <= 32'd0;
      bresp_q       <= 2'd0;
      rresp_q       <= 2'd0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      done_q <= '0;

      if (timeout_hit)  err_timeout_q <= 1'b1;
      else if (clr_err) err_timeout_q <= 1'b0;
      if (illegal_set)  err_illegal_q <= 1'b1;
      else if (clr_err) err_illegal_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q     <= pick_idx;
            ptr_q     <= ptr_d;
            devsel_q  <= pick_devsel;
            addr_q    <= pick_addr;
            wdata_q   <= pick_wdata;
            exp_en_q  <= pick_ee;
            exp_dir_q <= pick_ed;
            timer_q   <= '0;
            if (pick_wren && pick_rden) begin
              state_q <= ST_ERR;
              done_q  <= pick_onehot;
              rdata_q <= 32'd0;
              bresp_q <= 2'b10;
              rresp_q <= 2'b10;
            end else begin
              state_q    <= ST_BUSY;
              cfg_wren_q <= pick_wren;
              cfg_rden_q <= pick_rden;
            end
          end
        end
        ST_BUSY: begin
          if (bus.flsh_cfg_done) begin
            state_q    <= ST_DONE;
            done_q     <= gnt_onehot;
            rdata_q    <= bus.flsh_cfg_rdata;
            bresp_q    <= bus.flsh_cfg_bresp;
            rresp_q    <= bus.flsh_cfg_rresp;
            cfg_wren_q <= 1'b0;
            cfg_rden_q <= 1'b0;
          end else if (timer_q == TMO_LAST) begin
            state_q    <= ST_DONE;
            done_q     <= gnt_onehot;
            rdata_q    <= 32'hFFFF_FFFF;
            bresp_q    <= 2'b10;
            rresp_q    <= 2'b10;
            cfg_wren_q <= 1'b0;
            cfg_rden_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_done               = done_q;
  assign bus.req_rdata              = rdata_q;
  assign bus.req_bresp              = bresp_q;
  assign bus.req_rresp              = rresp_q;
  assign bus.cfg_flsh_devsel        = devsel_q;
  assign bus.cfg_flsh_addr          = addr_q;
  assign bus.cfg_flsh_wren          = cfg_wren_q;
  assign bus.cfg_flsh_wdata         = wdata_q;
  assign bus.cfg_flsh_rden          = cfg_rden_q;
  assign bus.cfg_flsh_expand_enable = exp_en_q;
  assign bus.cfg_flsh_expand_dir    = exp_dir_q;

  assign arb_busy     = (state_q != ST_IDLE);
  assign arb_grant_id = gnt_q;
  assign err_timeout  = err_timeout_q;
  assign err_illegal  = err_illegal_q;
endmodule
